// File: rtl/l4_trigger_delayer_pkg.sv
// l4_trigger_delayer_pkg: shared widths, L4 source indices and channel state type
package l4_trigger_delayer_pkg;
    localparam int NUM_L4_DEF      = 5;
    localparam int DELAY_BITS_DEF  = 8;
    localparam int PRETRG_BITS_DEF = 4;
    localparam int L4_RF0 = 0;
    localparam int L4_RF1 = 1;
    localparam int L4_CPU = 2;
    localparam int L4_CAL = 3;
    localparam int L4_EXT = 4;
    typedef enum logic {CH_IDLE, CH_COUNT} ch_state_e;
endpackage

// File: rtl/l4_delay_channel.sv
// l4_delay_channel: delays one L4 pulse by a latched count and latches its pretrigger
module l4_delay_channel
    import l4_trigger_delayer_pkg::*;
#(
    parameter int DELAY_BITS  = DELAY_BITS_DEF,
    parameter int PRETRG_BITS = PRETRG_BITS_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   trig_i,
    input  logic [DELAY_BITS-1:0]  delay_i,
    input  logic [PRETRG_BITS-1:0] pre_i,
    output logic                   emit_o,
    output logic                   busy_o,
    output logic                   drop_o,
    output logic [PRETRG_BITS-1:0] pre_o
);
    ch_state_e              state_q, state_d;
    logic [DELAY_BITS-1:0]  cnt_q, cnt_d;
    logic [PRETRG_BITS-1:0] pre_q, pre_d;
    logic                   drop_q, drop_d;

    // Next state: accept from IDLE, count down, emit at zero (a pulse on the emit edge reloads)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        drop_d  = 1'b0;
        emit_o  = 1'b0;
        case (state_q)
            CH_IDLE: if (trig_i) begin
                state_d = CH_COUNT;
                cnt_d   = delay_i;
                pre_d   = pre_i;
            end
            CH_COUNT: if (cnt_q != '0) begin
                cnt_d  = cnt_q - DELAY_BITS'(1);
                drop_d = trig_i;
            end else begin
                emit_o = 1'b1;
                if (trig_i) begin
                    cnt_d = delay_i;
                    pre_d = pre_i;
                end else begin
                    state_d = CH_IDLE;
                end
            end
            default: state_d = CH_IDLE;
        endcase
    end

    // State, counter, pretrigger latch and drop flag registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            drop_q  <= drop_d;
        end
    end

    assign busy_o = (state_q == CH_COUNT);
    assign drop_o = drop_q;
    assign pre_o  = pre_q;
endmodule

// File: rtl/l4_trigger_delayer.sv
// l4_trigger_delayer: per-L4 programmable trigger delay with merged mask/pretrigger event
module l4_trigger_delayer
    import l4_trigger_delayer_pkg::*;
#(
    parameter int NUM_L4      = NUM_L4_DEF,
    parameter int DELAY_BITS  = DELAY_BITS_DEF,
    parameter int PRETRG_BITS = PRETRG_BITS_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_L4-1:0]             l4_trig_i,
    input  logic [DELAY_BITS*NUM_L4-1:0]  delay_vector_i,
    input  logic [PRETRG_BITS*NUM_L4-1:0] pretrigger_vector_i,
    output logic [NUM_L4-1:0]             l4_trig_o,
    output logic                          trig_o,
    output logic [NUM_L4-1:0]             trig_mask_o,
    output logic [PRETRG_BITS-1:0]        pretrigger_o,
    output logic [NUM_L4-1:0]             busy_o,
    output logic [NUM_L4-1:0]             drop_o
);
    logic [NUM_L4-1:0]      emit;
    logic [PRETRG_BITS-1:0] ch_pre [NUM_L4];
    logic [PRETRG_BITS-1:0] pre_d, pre_q;
    logic [NUM_L4-1:0]      l4_trig_q;
    logic                   trig_q;

    for (genvar k = 0; k < NUM_L4; k++) begin : g_ch
        l4_delay_channel #(
            .DELAY_BITS (DELAY_BITS),
            .PRETRG_BITS(PRETRG_BITS)
        ) u_ch (
            .clk_i  (clk_i),
            .rst_n_i(rst_n_i),
            .trig_i (l4_trig_i[k]),
            .delay_i(delay_vector_i[DELAY_BITS*k +: DELAY_BITS]),
            .pre_i  (pretrigger_vector_i[PRETRG_BITS*k +: PRETRG_BITS]),
            .emit_o (emit[k]),
            .busy_o (busy_o[k]),
            .drop_o (drop_o[k]),
            .pre_o  (ch_pre[k])
        );
    end

    // Largest latched pretrigger among channels emitting on this edge
    always_comb begin
        pre_d = '0;
        for (int k = 0; k < NUM_L4; k++)
            if (emit[k] && ch_pre[k] > pre_d) pre_d = ch_pre[k];
    end

    // Register the merged event so it lines up with the per-channel pulses
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            l4_trig_q <= '0;
            trig_q    <= 1'b0;
            pre_q     <= '0;
        end else begin
            l4_trig_q <= emit;
            trig_q    <= |emit;
            pre_q     <= pre_d;
        end
    end

    assign l4_trig_o    = l4_trig_q;
    assign trig_mask_o  = l4_trig_q;
    assign trig_o       = trig_q;
    assign pretrigger_o = pre_q;
endmodule

// File: tb/tb_l4_trigger_delayer.sv
// tb_l4_trigger_delayer: directed table, corner sequences and random traffic against a timestamp model
module tb_l4_trigger_delayer;
    localparam int N  = 5;
    localparam int DB = 8;
    localparam int PB = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    trig = '0;
    logic [DB*N-1:0] dly = '0;
    logic [PB*N-1:0] pre = '0;
    logic [N-1:0]    l4_o, mask_o, busy_o, drop_o;
    logic            trig_o;
    logic [PB-1:0]   pre_o;

    l4_trigger_delayer dut (
        .clk_i(clk), .rst_n_i(rst_n), .l4_trig_i(trig),
        .delay_vector_i(dly), .pretrigger_vector_i(pre),
        .l4_trig_o(l4_o), .trig_o(trig_o), .trig_mask_o(mask_o),
        .pretrigger_o(pre_o), .busy_o(busy_o), .drop_o(drop_o)
    );

    always #5 clk = ~clk;

    int     n_chk = 0;
    int     n_fail = 0;
    longint cyc = 0;

    // Model: a pending trigger is an absolute edge number at which it fires
    bit           pend [N];
    longint       due  [N];
    int           mpre [N];
    logic [N-1:0] e_l4, e_busy, e_drop;
    int           e_pre;

    typedef struct {
        logic [N-1:0]    t;
        logic [DB*N-1:0] d;
        logic [PB*N-1:0] p;
        logic [N-1:0]    l4;
        logic [PB-1:0]   pr;
        logic [N-1:0]    bz;
        logic [N-1:0]    dr;
    } vec_t;
    vec_t tbl [17];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        e_l4 = '0; e_drop = '0; e_pre = 0;
        for (int k = 0; k < N; k++) begin
            if (pend[k] && due[k] == cyc) begin
                e_l4[k] = 1'b1;
                if (mpre[k] > e_pre) e_pre = mpre[k];
                pend[k] = 0;
            end
            if (trig[k]) begin
                if (!pend[k]) begin
                    pend[k] = 1;
                    due[k]  = cyc + longint'(dly[DB*k +: DB]) + 1;
                    mpre[k] = int'(pre[PB*k +: PB]);
                end else e_drop[k] = 1'b1;
            end
            e_busy[k] = pend[k];
        end
    endtask

    task automatic step(input logic [N-1:0] t);
        trig = t;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        trig = '0;
        check("l4", 32'(l4_o), 32'(e_l4));
        check("trig", 32'(trig_o), 32'(e_l4 != '0));
        check("mask", 32'(mask_o), 32'(e_l4));
        check("pre", 32'(pre_o), 32'(e_pre));
        check("busy", 32'(busy_o), 32'(e_busy));
        check("drop", 32'(drop_o), 32'(e_drop));
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_l4", 32'(l4_o), 0);
        check("rst_trig", 32'(trig_o), 0);
        check("rst_pre", 32'(pre_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_drop", 32'(drop_o), 0);
        for (int k = 0; k < N; k++) pend[k] = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int seen;
        int t_emit [N];
        int p_emit [N];
        logic [N-1:0] r;
        tbl = '{
            '{5'b00001, 40'h0, 20'h00005, 5'b00000, 4'd0,  5'b00001, 5'b00000},
            '{5'b00000, 40'h0, 20'h00005, 5'b00001, 4'd5,  5'b00000, 5'b00000},
            '{5'b01000, 40'h0002000000, 20'hC7000, 5'b00000, 4'd0,  5'b01000, 5'b00000},
            '{5'b00000, 40'h0002000000, 20'hC7000, 5'b00000, 4'd0,  5'b01000, 5'b00000},
            '{5'b10000, 40'h0002000000, 20'hC7000, 5'b00000, 4'd0,  5'b11000, 5'b00000},
            '{5'b00000, 40'h0002000000, 20'hC7000, 5'b11000, 4'd12, 5'b00000, 5'b00000},
            '{5'b00010, 40'h0000000400, 20'h00030, 5'b00000, 4'd0,  5'b00010, 5'b00000},
            '{5'b00000, 40'h0000000400, 20'h00030, 5'b00000, 4'd0,  5'b00010, 5'b00000},
            '{5'b00010, 40'h0000000400, 20'h00030, 5'b00000, 4'd0,  5'b00010, 5'b00010},
            '{5'b00000, 40'h0000000400, 20'h00030, 5'b00000, 4'd0,  5'b00010, 5'b00000},
            '{5'b00000, 40'h0000000400, 20'h00030, 5'b00000, 4'd0,  5'b00010, 5'b00000},
            '{5'b00010, 40'h0000000400, 20'h00030, 5'b00010, 4'd3,  5'b00010, 5'b00000},
            '{5'b00000, 40'h0000000400, 20'h00030, 5'b00000, 4'd0,  5'b00010, 5'b00000},
            '{5'b00000, 40'h0000000400, 20'h00030, 5'b00000, 4'd0,  5'b00010, 5'b00000},
            '{5'b00000, 40'h0000000400, 20'h00030, 5'b00000, 4'd0,  5'b00010, 5'b00000},
            '{5'b00000, 40'h0000000400, 20'h00030, 5'b00000, 4'd0,  5'b00010, 5'b00000},
            '{5'b00000, 40'h0000000400, 20'h00030, 5'b00010, 4'd3,  5'b00000, 5'b00000}
        };
        for (int k = 0; k < N; k++) pend[k] = 0;
        #1;
        check("init_l4", 32'(l4_o), 0);
        check("init_trig", 32'(trig_o), 0);
        check("init_busy", 32'(busy_o), 0);
        check("init_pre", 32'(pre_o), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Latency D=0, simultaneous merge, drop and emit-edge retrigger
        for (int i = 0; i < 17; i++) begin
            dly = tbl[i].d;
            pre = tbl[i].p;
            step(tbl[i].t);
            check("tbl_l4", 32'(l4_o), 32'(tbl[i].l4));
            check("tbl_trig", 32'(trig_o), 32'(tbl[i].l4 != '0));
            check("tbl_mask", 32'(mask_o), 32'(tbl[i].l4));
            check("tbl_pre", 32'(pre_o), 32'(tbl[i].pr));
            check("tbl_busy", 32'(busy_o), 32'(tbl[i].bz));
            check("tbl_drop", 32'(drop_o), 32'(tbl[i].dr));
        end

        // Reset mid-count loses the pending cpu emit
        dly = 40'h0000030000;
        pre = 20'h00900;
        step(5'b00100);
        step(5'b00000);
        do_reset();
        seen = 0;
        repeat (8) begin
            step(5'b00000);
            if (l4_o != '0 || drop_o != '0) seen++;
        end
        check("rst_noemit", 32'(seen), 0);

        // ch0 D=10 gives an 11-cycle latency
        dly = 40'h000000000A;
        step(5'b00001);
        n = 0;
        do begin step(5'b00000); n++; end while (!l4_o[0] && n < 40);
        check("lat10", 32'(n), 11);

        // Distinct delays per field, vector rewritten mid-count
        dly = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        pre = {4'd13, 4'd12, 4'd11, 4'd10, 4'd9};
        step(5'b11111);
        dly = {5{8'd200}};
        pre = '0;
        for (int k = 0; k < N; k++) begin t_emit[k] = -1; p_emit[k] = -1; end
        for (int s = 1; s <= 8; s++) begin
            step(5'b00000);
            for (int k = 0; k < N; k++)
                if (l4_o[k]) begin t_emit[k] = s; p_emit[k] = int'(pre_o); end
        end
        for (int k = 0; k < N; k++) begin
            check("field_time", 32'(t_emit[k]), 32'(k + 2));
            check("field_pre", 32'(p_emit[k]), 32'(k + 9));
        end

        // Maximum delay: 256-cycle latency, busy until the emit cycle
        dly = 40'h00000000FF;
        step(5'b00001);
        n = 0;
        seen = 0;
        do begin
            step(5'b00000);
            n++;
            if (!l4_o[0] && !busy_o[0]) seen++;
        end while (!l4_o[0] && n < 300);
        check("lat255", 32'(n), 256);
        check("busy255", 32'(seen), 0);
        check("busy255_end", 32'(busy_o[0]), 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                for (int k = 0; k < N; k++) begin
                    dly[DB*k +: DB] = ($urandom_range(0, 19) == 0) ? DB'($urandom) : DB'($urandom_range(0, 12));
                    pre[PB*k +: PB] = PB'($urandom);
                end
            for (int k = 0; k < N; k++) r[k] = ($urandom_range(0, 5) == 0);
            step(r);
            if (i % 1000 == 999) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
